// File: rtl/id_stage_pipe.sv
// RV32I/E (+M) decode stage: register file with optional write-through bypass,
// load-use hazard detection and a registered ID/EX boundary with valid/ready handshakes.
module id_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int RF_BYPASS = 1,
    parameter int M_EXT     = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic [10:0]     ex_ctrl,
    output logic            ex_illegal
);
    localparam int         AW   = $clog2(NUM_REGS);
    localparam logic [5:0] NREG = 6'(NUM_REGS);

    typedef enum logic [6:0] {
        OPC_R      = 7'b0110011,
        OPC_IMM    = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111
    } opcode_e;

    logic [XLEN-1:0] rf [NUM_REGS];
    logic            wb_wr_ok;
    logic [4:0]      d_rd, d_rs1, d_rs2;
    logic [2:0]      d_f3;
    logic [6:0]      d_f7;
    logic [31:0]     imm32;
    logic [10:0]     ctrl, d_ctrl;
    logic            bad_op, d_illegal, haz, adv;
    logic [XLEN-1:0] d_rs1_val, d_rs2_val;

    function automatic logic in_range(input logic [4:0] a);
        return {1'b0, a} < NREG;
    endfunction

    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        if (a != '0 && in_range(a)) begin
            if (RF_BYPASS != 0 && wb_wr_ok && wb_rd == a)
                v = wb_data;
            else
                v = rf[a[AW-1:0]];
        end
        return v;
    endfunction

    assign wb_wr_ok = wb_we && wb_rd != '0 && in_range(wb_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (wb_wr_ok) begin
            rf[wb_rd[AW-1:0]] <= wb_data;
        end
    end

    // ctrl bits: {RegWrite,ALUSrc,MemRead,MemWrite,Branch,Jump,Jump_r,MemToReg,MulDiv,ALUOp[1:0]}
    always_comb begin
        d_rd   = '0;
        d_rs1  = '0;
        d_rs2  = '0;
        d_f3   = '0;
        d_f7   = '0;
        imm32  = '0;
        ctrl   = '0;
        bad_op = 1'b0;
        case (if_instr[6:0])
            OPC_R: begin
                d_rd = if_instr[11:7]; d_rs1 = if_instr[19:15]; d_rs2 = if_instr[24:20];
                d_f3 = if_instr[14:12]; d_f7 = if_instr[31:25];
                ctrl = 11'b100_0000_0010;
                if (if_instr[31:25] == 7'b0000001) begin
                    ctrl[2] = 1'b1;
                    if (M_EXT == 0) bad_op = 1'b1;
                end
            end
            OPC_IMM, OPC_LOAD, OPC_JALR: begin
                d_rd = if_instr[11:7]; d_rs1 = if_instr[19:15]; d_f3 = if_instr[14:12];
                imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
                case (if_instr[6:0])
                    OPC_LOAD: ctrl = 11'b111_0000_1000;
                    OPC_JALR: ctrl = 11'b110_0001_0000;
                    default:  ctrl = 11'b110_0000_0000;
                endcase
            end
            OPC_STORE: begin
                d_rs1 = if_instr[19:15]; d_rs2 = if_instr[24:20]; d_f3 = if_instr[14:12];
                imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
                ctrl  = 11'b010_1000_0000;
            end
            OPC_BRANCH: begin
                d_rs1 = if_instr[19:15]; d_rs2 = if_instr[24:20]; d_f3 = if_instr[14:12];
                imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                         if_instr[30:25], if_instr[11:8], 1'b0};
                ctrl  = 11'b000_0100_0001;
            end
            OPC_LUI, OPC_AUIPC: begin
                d_rd  = if_instr[11:7];
                imm32 = {if_instr[31:12], 12'b0};
                ctrl  = (if_instr[6:0] == OPC_AUIPC) ? 11'b110_0000_0011 : 11'b110_0000_0000;
            end
            OPC_JAL: begin
                d_rd  = if_instr[11:7];
                imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                         if_instr[20], if_instr[30:21], 1'b0};
                ctrl  = 11'b100_0010_0000;
            end
            default: bad_op = 1'b1;
        endcase
        d_illegal = bad_op || !in_range(d_rs1) || !in_range(d_rs2) || !in_range(d_rd);
        d_ctrl    = d_illegal ? '0 : ctrl;
        d_rs1_val = rf_read(d_rs1);
        d_rs2_val = rf_read(d_rs2);
    end

    // Unused specifiers are already zeroed by decode, and ex_rd!=0 keeps them from matching.
    assign haz = ex_valid && ex_ctrl[8] && ex_rd != '0 && (ex_rd == d_rs1 || ex_rd == d_rs2);
    assign adv = !ex_valid || ex_ready;
    assign if_ready = flush || (adv && !haz);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_rs1_val <= '0;
            ex_rs2_val <= '0;
            ex_imm     <= '0;
            ex_rd      <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_funct3  <= '0;
            ex_funct7  <= '0;
            ex_ctrl    <= '0;
            ex_illegal <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (adv) begin
            if (haz) begin
                ex_valid <= 1'b0;
            end else begin
                ex_valid   <= if_valid;
                ex_pc      <= if_pc;
                ex_rs1_val <= d_rs1_val;
                ex_rs2_val <= d_rs2_val;
                ex_imm     <= XLEN'(signed'(imm32));
                ex_rd      <= d_rd;
                ex_rs1     <= d_rs1;
                ex_rs2     <= d_rs2;
                ex_funct3  <= d_f3;
                ex_funct7  <= d_f7;
                ex_ctrl    <= d_ctrl;
                ex_illegal <= d_illegal;
            end
        end
    end
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: default instance plus an RV32E / no-M / no-bypass
// instance sharing the same stimulus.
module tb_id_stage_pipe;
    logic        clk = 1'b0;
    logic        rst_n, if_valid, flush, wb_we, ex_ready;
    logic [31:0] if_instr, if_pc, wb_data;
    logic [4:0]  wb_rd;

    logic        if_ready, ex_valid, ex_illegal;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic [10:0] ex_ctrl;

    logic        e_if_ready, e_ex_valid, e_ex_illegal;
    logic [31:0] e_ex_pc, e_ex_rs1_val, e_ex_rs2_val, e_ex_imm;
    logic [4:0]  e_ex_rd, e_ex_rs1, e_ex_rs2;
    logic [2:0]  e_ex_funct3;
    logic [6:0]  e_ex_funct7;
    logic [10:0] e_ex_ctrl;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_stage_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .wb_we(wb_we),
        .wb_rd(wb_rd), .wb_data(wb_data), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_funct3(ex_funct3),
        .ex_funct7(ex_funct7), .ex_ctrl(ex_ctrl), .ex_illegal(ex_illegal)
    );

    id_stage_pipe #(.XLEN(32), .NUM_REGS(16), .RF_BYPASS(0), .M_EXT(0)) u_dut_e (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(e_if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .wb_we(wb_we),
        .wb_rd(wb_rd), .wb_data(wb_data), .ex_valid(e_ex_valid), .ex_ready(ex_ready),
        .ex_pc(e_ex_pc), .ex_rs1_val(e_ex_rs1_val), .ex_rs2_val(e_ex_rs2_val), .ex_imm(e_ex_imm),
        .ex_rd(e_ex_rd), .ex_rs1(e_ex_rs1), .ex_rs2(e_ex_rs2), .ex_funct3(e_ex_funct3),
        .ex_funct7(e_ex_funct7), .ex_ctrl(e_ex_ctrl), .ex_illegal(e_ex_illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1_val, rs2_val, imm;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [10:0] ctrl;
        logic        ill;
        logic        e_ill;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
    endtask

    initial begin
        // instr, rs1_val, rs2_val, imm, rd, rs1, rs2, f3, f7, ctrl, ill, e_ill
        tbl[0]  = '{32'h00328093, 32'd100,      32'h0,        32'd3,        5'd1, 5'd5, 5'd0, 3'd0, 7'h00, 11'h600, 1'b0, 1'b0}; // ADDI x1,x5,3
        tbl[1]  = '{32'h002081B3, 32'h10,       32'hFFFFFFF0, 32'h0,        5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 11'h402, 1'b0, 1'b0}; // ADD x3,x1,x2
        tbl[2]  = '{32'h40110233, 32'hFFFFFFF0, 32'h10,       32'h0,        5'd4, 5'd2, 5'd1, 3'd0, 7'h20, 11'h402, 1'b0, 1'b0}; // SUB x4,x2,x1
        tbl[3]  = '{32'h02208333, 32'h10,       32'hFFFFFFF0, 32'h0,        5'd6, 5'd1, 5'd2, 3'd0, 7'h01, 11'h406, 1'b0, 1'b1}; // MUL x6,x1,x2
        tbl[4]  = '{32'h0020A423, 32'h10,       32'hFFFFFFF0, 32'd8,        5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 11'h280, 1'b0, 1'b0}; // SW x2,8(x1)
        tbl[5]  = '{32'hFE208CE3, 32'h10,       32'hFFFFFFF0, 32'hFFFFFFF8, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 11'h041, 1'b0, 1'b0}; // BEQ x1,x2,-8
        tbl[6]  = '{32'h010000EF, 32'h0,        32'h0,        32'd16,       5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 11'h420, 1'b0, 1'b0}; // JAL x1,+16
        tbl[7]  = '{32'h00008067, 32'h10,       32'h0,        32'h0,        5'd0, 5'd1, 5'd0, 3'd0, 7'h00, 11'h610, 1'b0, 1'b0}; // JALR x0,0(x1)
        tbl[8]  = '{32'hFFFFF297, 32'h0,        32'h0,        32'hFFFFF000, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 11'h603, 1'b0, 1'b0}; // AUIPC x5
        tbl[9]  = '{32'h123454B7, 32'h0,        32'h0,        32'h12345000, 5'd9, 5'd0, 5'd0, 3'd0, 7'h00, 11'h600, 1'b0, 1'b0}; // LUI x9
        tbl[10] = '{32'h0000007F, 32'h0,        32'h0,        32'h0,        5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 11'h000, 1'b1, 1'b1}; // bad opcode
        tbl[11] = '{32'hFFC0A103, 32'h10,       32'h0,        32'hFFFFFFFC, 5'd2, 5'd1, 5'd0, 3'd2, 7'h00, 11'h708, 1'b0, 1'b0}; // LW x2,-4(x1)

        rst_n = 1'b0; if_valid = 1'b0; flush = 1'b0; wb_we = 1'b0; ex_ready = 1'b1;
        if_instr = '0; if_pc = '0; wb_rd = '0; wb_data = '0;
        repeat (2) tick;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_pc", ex_pc, 32'd0);
        chk("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
        chk("rst_ex_imm", ex_imm, 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd1);

        rst_n = 1'b1;
        wb_we = 1'b1;
        wb_rd = 5'd1; wb_data = 32'h10;       tick;
        wb_rd = 5'd2; wb_data = 32'hFFFFFFF0; tick;
        wb_rd = 5'd5; wb_data = 32'd100;      tick;
        wb_we = 1'b0;

        for (int i = 0; i < 12; i++) begin
            present(tbl[i].instr, 32'h1000 + 32'(i * 4));
            #1;
            chk($sformatf("v%0d_if_ready", i), 32'(if_ready), 32'd1);
            tick;
            chk($sformatf("v%0d_valid", i), 32'(ex_valid), 32'd1);
            chk($sformatf("v%0d_pc", i), ex_pc, 32'h1000 + 32'(i * 4));
            chk($sformatf("v%0d_rs1_val", i), ex_rs1_val, tbl[i].rs1_val);
            chk($sformatf("v%0d_rs2_val", i), ex_rs2_val, tbl[i].rs2_val);
            chk($sformatf("v%0d_imm", i), ex_imm, tbl[i].imm);
            chk($sformatf("v%0d_regs", i), {17'd0, ex_rd, ex_rs1, ex_rs2},
                {17'd0, tbl[i].rd, tbl[i].rs1, tbl[i].rs2});
            chk($sformatf("v%0d_funct", i), {22'd0, ex_funct3, ex_funct7}, {22'd0, tbl[i].f3, tbl[i].f7});
            chk($sformatf("v%0d_ctrl", i), 32'(ex_ctrl), 32'(tbl[i].ctrl));
            chk($sformatf("v%0d_illegal", i), 32'(ex_illegal), 32'(tbl[i].ill));
            chk($sformatf("v%0d_e_illegal", i), 32'(e_ex_illegal), 32'(tbl[i].e_ill));
            chk($sformatf("v%0d_e_ctrl", i), 32'(e_ex_ctrl), tbl[i].e_ill ? 32'd0 : 32'(tbl[i].ctrl));
        end

        // Load-use: LW x2 is in ID/EX, ADD x3,x2,x2 must wait one bubble.
        present(32'h002101B3, 32'h2000);
        #1;
        chk("haz_if_ready", 32'(if_ready), 32'd0);
        tick;
        chk("haz_bubble", 32'(ex_valid), 32'd0);
        chk("haz_if_ready_after", 32'(if_ready), 32'd1);
        tick;
        chk("haz_add_valid", 32'(ex_valid), 32'd1);
        chk("haz_add_rd", 32'(ex_rd), 32'd3);
        chk("haz_add_pc", ex_pc, 32'h2000);

        // LW followed by LUI x2: no source operands, no stall.
        present(32'hFFC0A103, 32'h2004);
        tick;
        present(32'h00001137, 32'h2008);
        #1;
        chk("lui_no_stall", 32'(if_ready), 32'd1);
        tick;
        chk("lui_rd", 32'(ex_rd), 32'd2);
        chk("lui_ctrl", 32'(ex_ctrl), 32'h600);

        // Same-cycle write x6=42 while decoding ADD x7,x6,x6.
        wb_we = 1'b1; wb_rd = 5'd6; wb_data = 32'd42;
        present(32'h006303B3, 32'h3000);
        tick;
        wb_we = 1'b0;
        chk("byp_rs1", ex_rs1_val, 32'd42);
        chk("byp_rs2", ex_rs2_val, 32'd42);
        chk("nobyp_rs1", e_ex_rs1_val, 32'd0);
        chk("nobyp_rs2", e_ex_rs2_val, 32'd0);
        present(32'h006303B3, 32'h3004);
        tick;
        chk("nobyp_later_rs1", e_ex_rs1_val, 32'd42);

        // Stall: ex_ready low for 3 cycles holds ADDI x8,x0,7.
        present(32'h00700413, 32'h4000);
        tick;
        ex_ready = 1'b0;
        present(32'h00900493, 32'h4004);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_if_ready", c), 32'(if_ready), 32'd0);
            tick;
            chk($sformatf("stall%0d_valid", c), 32'(ex_valid), 32'd1);
            chk($sformatf("stall%0d_rd", c), 32'(ex_rd), 32'd8);
            chk($sformatf("stall%0d_imm", c), ex_imm, 32'd7);
            chk($sformatf("stall%0d_pc", c), ex_pc, 32'h4000);
        end
        ex_ready = 1'b1;
        tick;
        chk("stall_release_rd", 32'(ex_rd), 32'd9);
        ex_ready = 1'b0;
        present(32'h00A00513, 32'h4008);
        tick;
        chk("stall2_hold_rd", 32'(ex_rd), 32'd9);
        // Flush together with ex_ready and a WB write in the same cycle.
        flush = 1'b1; ex_ready = 1'b1;
        wb_we = 1'b1; wb_rd = 5'd10; wb_data = 32'h55;
        #1;
        chk("flush_if_ready", 32'(if_ready), 32'd1);
        tick;
        flush = 1'b0; wb_we = 1'b0;
        chk("flush_valid", 32'(ex_valid), 32'd0);
        present(32'h000505B3, 32'h5000);
        tick;
        chk("flush_wb_kept", ex_rs1_val, 32'h55);
        chk("post_flush_valid", 32'(ex_valid), 32'd1);

        // RV32E: x20 is out of range; WB to x20 ignored there.
        wb_we = 1'b1; wb_rd = 5'd20; wb_data = 32'h77;
        present(32'h00108A33, 32'h6000);
        tick;
        wb_we = 1'b0;
        chk("e_x20_illegal", 32'(e_ex_illegal), 32'd1);
        chk("e_x20_ctrl", 32'(e_ex_ctrl), 32'd0);
        chk("e_x20_valid", 32'(e_ex_valid), 32'd1);
        chk("i_x20_legal", 32'(ex_illegal), 32'd0);
        present(32'h000A0AB3, 32'h6004);
        tick;
        chk("i_x20_read", ex_rs1_val, 32'h77);
        chk("e_x20_read", e_ex_rs1_val, 32'd0);
        chk("e_x20_src_illegal", 32'(e_ex_illegal), 32'd1);

        // Asynchronous reset mid-stream.
        present(32'h00328093, 32'h7000);
        tick;
        chk("pre_rst_valid", 32'(ex_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(ex_valid), 32'd0);
        chk("async_rst_pc", ex_pc, 32'd0);
        chk("async_rst_rs1", ex_rs1_val, 32'd0);
        #1;
        rst_n = 1'b1;
        present(32'h00128633, 32'h8000);
        tick;
        chk("rf_cleared_rs1", ex_rs1_val, 32'd0);
        chk("rf_cleared_rs2", ex_rs2_val, 32'd0);
        chk("rf_cleared_valid", 32'(ex_valid), 32'd1);

        if_valid = 1'b0;
        tick;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
